// File: rtl/imem_ctrl.sv
// imem_ctrl: instruction-memory responder on the slave side of the fetch
// interface. Accepts one fetch at a time, answers after LATENCY edges,
// supports flush on redirect, and has a loader port that fills the array.
module imem_ctrl #(
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter int unsigned LATENCY        = 1,
  parameter int unsigned MEM_ADDR_WIDTH = 32,
  parameter int unsigned REG_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      imem_rd_en,
  input  logic [MEM_ADDR_WIDTH-1:0] pc,
  input  logic                      flush,
  output logic                      ready,
  output logic [REG_DATA_WIDTH-1:0] inst_imem,
  output logic                      inst_valid,
  output logic                      addr_err,
  input  logic                      load_en,
  input  logic [MEM_ADDR_WIDTH-1:0] load_addr,
  input  logic [REG_DATA_WIDTH-1:0] load_data
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [MEM_ADDR_WIDTH:0] ADDR_LIMIT = (MEM_ADDR_WIDTH + 1)'(4 * DEPTH_WORDS);
  localparam logic [REG_DATA_WIDTH-1:0] NOP_INST = REG_DATA_WIDTH'(32'h0000_0013);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // True when a byte address falls inside the array
  function automatic logic in_range(input logic [MEM_ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < ADDR_LIMIT);
  endfunction

  logic [REG_DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      err_q, err_d;
  logic                      valid_d;
  logic [REG_DATA_WIDTH-1:0] data_d;
  logic                      aerr_d;

  logic                      accept;
  logic [IDX_W-1:0]          req_idx;
  logic                      req_err;
  logic [IDX_W-1:0]          load_idx;
  logic                      load_ok;

  // Request decode and handshake; ready is held low while reset is asserted
  assign ready    = rst && ((state_q == S_IDLE) || (cnt_q == '0));
  assign accept   = imem_rd_en && ready;
  assign req_idx  = pc[IDX_W+1:2];
  assign req_err  = (pc[1:0] != 2'b00) || !in_range(pc);
  assign load_idx = load_addr[IDX_W+1:2];
  assign load_ok  = in_range(load_addr);

  // Next-state, counter, latched request and registered response values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    err_d   = err_q;
    valid_d = 1'b0;
    data_d  = inst_imem;
    aerr_d  = addr_err;

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          valid_d = 1'b1;
          data_d  = err_q ? NOP_INST : mem[idx_q];
          aerr_d  = err_q;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Redirect drops the outstanding fetch and any response due this edge
    if (flush) begin
      valid_d = 1'b0;
      data_d  = inst_imem;
      aerr_d  = addr_err;
      state_d = S_IDLE;
      cnt_d   = '0;
    end

    // ready already excludes WAIT with cnt!=0, so an accept always loads
    if (accept) begin
      state_d = S_WAIT;
      cnt_d   = CNT_INIT;
      idx_d   = req_idx;
      err_d   = req_err;
    end
  end

  // FSM, latched request and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      inst_valid <= 1'b0;
      inst_imem  <= '0;
      addr_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      inst_valid <= valid_d;
      inst_imem  <= data_d;
      addr_err   <= aerr_d;
    end
  end

  // Loader write port; the array is not touched by reset
  always_ff @(posedge clk) begin
    if (load_en && load_ok) begin
      mem[load_idx] <= load_data;
    end
  end

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl: one LATENCY=1 and one LATENCY=3 instance
// sharing clock, reset and loader; responses checked through per-instance
// scoreboards holding expected data, error flag and due cycle.
module tb_imem_ctrl;

  localparam int unsigned DEPTH = 1024;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  logic        rd1, fl1, rdy1, val1, aerr1;
  logic [31:0] pc1, inst1;
  logic        rd3, fl3, rdy3, val3, aerr3;
  logic [31:0] pc3, inst3;

  int   checks;
  int   failures;
  int   cyc;
  exp_t q1[$];
  exp_t q3[$];

  imem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(1), .MEM_ADDR_WIDTH(32), .REG_DATA_WIDTH(32)) u1 (
    .clk(clk), .rst(rst), .imem_rd_en(rd1), .pc(pc1), .flush(fl1), .ready(rdy1),
    .inst_imem(inst1), .inst_valid(val1), .addr_err(aerr1),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  imem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(3), .MEM_ADDR_WIDTH(32), .REG_DATA_WIDTH(32)) u3 (
    .clk(clk), .rst(rst), .imem_rd_en(rd3), .pc(pc3), .flush(fl3), .ready(rdy3),
    .inst_imem(inst3), .inst_valid(val3), .addr_err(aerr3),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected response for a request accepted at the coming edge
  task automatic push1(input logic [31:0] d, input logic e);
    exp_t x;
    x.data = d; x.err = e; x.cyc = cyc + 2;
    q1.push_back(x);
  endtask

  task automatic push3(input logic [31:0] d, input logic e);
    exp_t x;
    x.data = d; x.err = e; x.cyc = cyc + 4;
    q3.push_back(x);
  endtask

  // Compare both instances' response outputs against their scoreboards
  task automatic monitor();
    exp_t x;
    logic due;
    due = (q1.size() > 0) && (q1[0].cyc == cyc);
    chk("u1_inst_valid", 32'(val1), 32'(due));
    if (due) begin
      x = q1.pop_front();
      chk("u1_inst_imem", inst1, x.data);
      chk("u1_addr_err", 32'(aerr1), 32'(x.err));
    end
    due = (q3.size() > 0) && (q3[0].cyc == cyc);
    chk("u3_inst_valid", 32'(val3), 32'(due));
    if (due) begin
      x = q3.pop_front();
      chk("u3_inst_imem", inst3, x.data);
      chk("u3_addr_err", 32'(aerr3), 32'(x.err));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  initial begin
    logic [31:0] prog [4];
    checks = 0; failures = 0; cyc = 0;
    prog[0] = 32'h0050_0093; prog[1] = 32'h00A0_0113;
    prog[2] = 32'h0020_81B3; prog[3] = 32'h0000_0013;
    rst = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    rd1 = 1'b0; pc1 = '0; fl1 = 1'b0;
    rd3 = 1'b0; pc3 = '0; fl3 = 1'b0;

    // Reset state
    step(); step();
    chk("rst_u1_inst", inst1, 32'h0);
    chk("rst_u1_aerr", 32'(aerr1), 32'h0);
    chk("rst_u1_ready", 32'(rdy1), 32'h0);
    chk("rst_u3_inst", inst3, 32'h0);
    chk("rst_u3_ready", 32'(rdy3), 32'h0);

    // Program load while held in reset; an out-of-range write must be dropped
    for (int i = 0; i < 4; i++) load(32'(i * 4), prog[i]);
    load(32'(4 * DEPTH - 4), 32'h1234_5678);
    load(32'(4 * DEPTH), 32'hBADB_AD00);

    rst = 1'b1;
    step();
    chk("post_rst_u1_ready", 32'(rdy1), 32'h1);
    chk("post_rst_u3_ready", 32'(rdy3), 32'h1);

    // LATENCY=1 back-to-back fetches, ready stays high
    for (int i = 0; i < 4; i++) begin
      rd1 = 1'b1; pc1 = 32'(i * 4);
      chk("b2b_ready", 32'(rdy1), 32'h1);
      push1(prog[i], 1'b0);
      step();
    end
    rd1 = 1'b0;
    chk("b2b_ready_end", 32'(rdy1), 32'h1);
    step(); step();

    // LATENCY=3 fetch of pc=8 then a request at the cnt==0 edge
    rd3 = 1'b1; pc3 = 32'h8;
    push3(prog[2], 1'b0);
    step();
    rd3 = 1'b0;
    chk("l3_ready_w1", 32'(rdy3), 32'h0);
    step();
    chk("l3_ready_w2", 32'(rdy3), 32'h0);
    step();
    chk("l3_ready_cnt0", 32'(rdy3), 32'h1);
    rd3 = 1'b1; pc3 = 32'h4;
    push3(prog[1], 1'b0);
    step();
    rd3 = 1'b0;
    step(); step(); step();
    chk("l3_ready_idle", 32'(rdy3), 32'h1);

    // Misaligned, just-out-of-range and last in-range word
    rd1 = 1'b1; pc1 = 32'h4;  push1(prog[1], 1'b0); step();
    rd1 = 1'b1; pc1 = 32'h6;  push1(32'h0000_0013, 1'b1); step();
    rd1 = 1'b1; pc1 = 32'(4 * DEPTH); push1(32'h0000_0013, 1'b1); step();
    rd1 = 1'b1; pc1 = 32'(4 * DEPTH - 4); push1(32'h1234_5678, 1'b0); step();
    rd1 = 1'b0;
    step(); step();

    // LATENCY=3 flush one cycle after accept; request during cnt!=0 ignored
    rd3 = 1'b1; pc3 = 32'h4;
    step();
    rd3 = 1'b1; pc3 = 32'h8; fl3 = 1'b1;
    chk("flush_ready_busy", 32'(rdy3), 32'h0);
    step();
    rd3 = 1'b0; fl3 = 1'b0;
    chk("flush_ready_idle", 32'(rdy3), 32'h1);
    step(); step(); step(); step();
    rd3 = 1'b1; pc3 = 32'h0;
    push3(prog[0], 1'b0);
    step();
    rd3 = 1'b0;
    step(); step(); step();

    // LATENCY=1 flush with a new request on the response edge
    rd1 = 1'b1; pc1 = 32'h4;
    step();
    rd1 = 1'b1; pc1 = 32'hC; fl1 = 1'b1;
    push1(prog[3], 1'b0);
    step();
    rd1 = 1'b0; fl1 = 1'b0;
    step(); step();

    // Reset while u3 waits: outputs cleared, in-flight fetch dropped
    rd3 = 1'b1; pc3 = 32'h4;
    step();
    rd3 = 1'b0; rst = 1'b0;
    step();
    chk("rst_wait_u3_inst", inst3, 32'h0);
    chk("rst_wait_u3_aerr", 32'(aerr3), 32'h0);
    chk("rst_wait_u3_ready", 32'(rdy3), 32'h0);
    chk("rst_wait_u1_inst", inst1, 32'h0);
    rst = 1'b1;
    step(); step(); step(); step();

    // Array survives reset
    rd1 = 1'b1; pc1 = 32'h4; push1(prog[1], 1'b0); step();
    rd1 = 1'b0; step();

    // Read-before-write on the response edge, new data on the next fetch
    rd1 = 1'b1; pc1 = 32'h8; push1(prog[2], 1'b0);
    step();
    rd1 = 1'b0;
    load(32'h8, 32'hDEAD_BEEF);
    rd1 = 1'b1; pc1 = 32'h8; push1(32'hDEAD_BEEF, 1'b0);
    step();
    rd1 = 1'b0;
    step(); step(); step();

    chk("u1_sb_empty", 32'(q1.size()), 32'h0);
    chk("u3_sb_empty", 32'(q3.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
